// File: rtl/mcycle_sched_pkg.sv
// Shared definitions for the multi-cycle unit issue controller.
// Provides the FSM state encoding and the default watchdog limit.
package mcycle_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mcycle_watchdog.sv
// RUN-cycle counter with clear/enable/saturate, expiry flag and captured count.
// Ports: clk/rst, clear, enable, capture in; expired, last_cycles out.
module mcycle_watchdog
    import mcycle_sched_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             capture,
    output logic             expired,
    output logic [CNT_W-1:0] last_cycles
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt;

    // Expiry is seen in the RUN cycle whose count is TIMEOUT-1.
    assign expired = enable && (cnt == LIMIT - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            last_cycles <= '0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (enable && cnt != LIMIT) begin
                cnt <= cnt + 1'b1;
            end
            // Count includes the completing cycle itself.
            if (capture) begin
                last_cycles <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcycle_sched.sv
// Issue/sequencing FSM for the shared multi-cycle unit in Execute.
// Ports: E-stage request in, unit start/op out, unit done/result in,
// M-stage handshake, stall/hazard status, watchdog pulse and cycle count.
module mcycle_sched
    import mcycle_sched_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 1,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ReqValid,
    input  logic [OP_W-1:0]   ReqOp,
    input  logic [REG_W-1:0]  ReqWA3,
    input  logic              ReqRegWrite,
    input  logic              Flush,
    output logic              UnitStart,
    output logic [OP_W-1:0]   UnitOp,
    input  logic              UnitBusy,
    input  logic              UnitDone,
    input  logic [DATA_W-1:0] UnitResult,
    input  logic              WbReady,
    output logic              StallPipe,
    output logic              ResultValid,
    output logic [DATA_W-1:0] Result,
    output logic [REG_W-1:0]  ResultWA3,
    output logic              ResultRegWrite,
    output logic              PendingValid,
    output logic              Timeout,
    output logic [CNT_W-1:0]  LastCycles
);

    state_t state;

    logic accept;
    logic done_ok;
    logic expired;
    logic unused_busy;

    // Busy is informational only; completion relies on Done and the watchdog.
    assign unused_busy = UnitBusy;

    assign accept = (state == IDLE) && ReqValid && !Flush;

    // The start cycle is marked by the registered UnitStart pulse, so a
    // Done seen then belongs to a previous op and is ignored.
    assign done_ok = (state == RUN) && !UnitStart && UnitDone && !Flush;

    assign StallPipe = accept
                     || (state == RUN)
                     || ((state == DONE) && !WbReady);

    assign PendingValid = (state != IDLE);

    mcycle_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wdog (
        .clk         (CLK),
        .rst         (Reset),
        .clear       (state != RUN),
        .enable      (state == RUN),
        .capture     (done_ok),
        .expired     (expired),
        .last_cycles (LastCycles)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            UnitStart      <= 1'b0;
            UnitOp         <= '0;
            ResultValid    <= 1'b0;
            Result         <= '0;
            ResultWA3      <= '0;
            ResultRegWrite <= 1'b0;
            Timeout        <= 1'b0;
        end else begin
            UnitStart <= 1'b0;
            Timeout   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        UnitOp         <= ReqOp;
                        ResultWA3      <= ReqWA3;
                        ResultRegWrite <= ReqRegWrite;
                        UnitStart      <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (Flush) begin
                        state <= IDLE;
                    end else if (done_ok) begin
                        Result      <= UnitResult;
                        ResultValid <= 1'b1;
                        state       <= DONE;
                    end else if (expired) begin
                        Timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DONE: begin
                    // Flush is ignored: the op has already completed.
                    if (WbReady) begin
                        ResultValid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mcycle_sched.md
Name: mcycle_sched

Overview:
Issue/sequencing controller for the shared multi-cycle unit (MCycle multiplier/divider, or FPUnit) in the Execute stage of the 5-stage ARM pipeline.
- Accepts one request at a time from E-stage decode and pulses Start to the unit.
- Holds the front of the pipeline stalled while the unit runs.
- Buffers the result until the M-stage write slot is free.
- Supports flush-abort and a watchdog timeout.
- Replaces the ad-hoc Start/Busy/Done stalling in the hazard unit with one explicit FSM.

Parameters:
DATA_W, 32, operand/result width
OP_W, 1, unit opcode width (MCycleOp)
REG_W, 4, register address width
TIMEOUT, 64, max RUN cycles before abort (≥2, ≤2^CNT_W−1)
CNT_W, 8, cycle counter width

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
ReqValid  in  1  E-stage instruction needs the unit (M_StartE qualified by CondLogic)
ReqOp  in  OP_W  operation for the unit
ReqWA3  in  REG_W  destination register
ReqRegWrite  in  1  destination is actually written
Flush  in  1  kill request/in-flight op (older branch/exception)
UnitStart  out  1  one-cycle start pulse to unit
UnitOp  out  OP_W  latched opcode, stable while state≠IDLE
UnitBusy  in  1  unit busy (informational; not required for completion)
UnitDone  in  1  unit result valid this cycle
UnitResult  in  DATA_W  unit result
WbReady  in  1  M-stage accepts buffered result this cycle
StallPipe  out  1  hold F/D/E pipeline registers
ResultValid  out  1  buffered result present
Result  out  DATA_W  buffered result
ResultWA3  out  REG_W  destination of buffered/pending op
ResultRegWrite  out  1  write-enable for buffered result
PendingValid  out  1  an op is in RUN or DONE (for hazard unit)
Timeout  out  1  one-cycle pulse: watchdog abort
LastCycles  out  CNT_W  RUN-cycle count of last completed op

Behaviour:
- States: IDLE, RUN, DONE. Reset (async) → IDLE.
- Reset values: all outputs 0, LastCycles=0, latched op/WA3/RegWrite=0, counter=0.
- IDLE:
  - ReqValid & !Flush → latch ReqOp/ReqWA3/ReqRegWrite, cnt←0, go RUN.
  - ReqValid & Flush → ignored, stay IDLE.
- RUN:
  - UnitStart=1 only in the first RUN cycle (registered pulse, one cycle after accept).
  - cnt increments every RUN cycle; saturates at TIMEOUT.
  - UnitDone is sampled only in RUN cycles after the start cycle; Done in the start cycle is stale and ignored.
  - UnitDone & !Flush → Result←UnitResult, LastCycles←cnt+1, go DONE.
  - Flush (any RUN cycle, including together with Done) → discard, go IDLE, no result.
  - cnt reaches TIMEOUT−1 with no Done → Timeout pulse next cycle, go IDLE, no result, LastCycles unchanged.
- DONE:
  - ResultValid=1; Result/ResultWA3/ResultRegWrite held stable.
  - WbReady → go IDLE (result consumed this cycle).
  - Flush in DONE is ignored: the op is architecturally complete.
- StallPipe = (IDLE & ReqValid & !Flush) | RUN | (DONE & !WbReady). Combinational, so the requesting instruction is frozen in E from its first cycle.
- PendingValid = state≠IDLE; ResultWA3 valid whenever PendingValid.
- Back-to-back: DONE & WbReady → IDLE. A new request is accepted the following cycle at earliest, so minimum 1 bubble between unit ops.
- Minimum accept-to-ResultValid latency: 3 cycles (accept, start, Done).
- UnitBusy is unused for transitions. If UnitBusy=0 in RUN past the start cycle with no Done, it is not an error; the watchdog handles it.
- Reset asserted mid-RUN/DONE: immediate IDLE, UnitStart and all other outputs drop asynchronously.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default TIMEOUT constant.
- One sub-module, mcycle_watchdog: CNT_W counter with clear/enable/saturate, expiry flag and captured count. Everything else stays in mcycle_sched.

Test Plan:
- Basic multiply: ReqValid with ReqOp=0, WA3=4'd5; Done on 4th RUN cycle, UnitResult=32'h0000_0C35, WbReady=1 → UnitStart pulse exactly 1 cycle after accept; ResultValid with Result=32'h0000_0C35, ResultWA3=5; LastCycles=4; StallPipe falls the cycle WbReady is seen.
- Backpressure: Done arrives with WbReady=0 for 3 cycles → state DONE; StallPipe=1, Result held for all 3 cycles; WbReady=1 → IDLE next cycle.
- Flush in RUN: Flush on 2nd RUN cycle with Done also asserted → IDLE, ResultValid never 1, LastCycles unchanged.
- Timeout: TIMEOUT=8, Done never asserted → Timeout pulses once after 8 RUN cycles, state IDLE, PendingValid=0.
- Async reset mid-RUN: Reset asserted between clock edges → UnitStart, StallPipe, PendingValid go 0 immediately. After release, a new request is accepted normally.
- Stale Done: UnitDone held high in the start cycle only → ignored, FSM remains RUN; completes on a later Done.
